// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
//   DIV_W          default divisor / quotient / remainder width
//   S_IDLE/RUN/DONE  FSM state encoding
package div_pkg;

    localparam int DIV_W = 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/fadder.sv
// One-bit full adder.
//   a, b, cin  addend bits and carry in
//   s, cout    sum bit and carry out
module fadder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/sub_cell.sv
// Ripple trial subtractor: diff = a - b computed as a + ~b + 1.
//   a, b    N-bit operands
//   diff    N-bit difference (two's complement wrap)
//   borrow  high when a < b (unsigned)
module sub_cell #(
    parameter int N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow
);

    logic [N:0] carry_s;

    assign carry_s[0] = 1'b1;

    for (genvar i = 0; i < N; i++) begin : g_bit
        fadder u_fa (
            .a    (a[i]),
            .b    (~b[i]),
            .cin  (carry_s[i]),
            .s    (diff[i]),
            .cout (carry_s[i+1])
        );
    end

    // No carry out of the top bit means the subtraction went below zero.
    assign borrow = ~carry_s[N];

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider: 2W-bit dividend / W-bit divisor, one
// quotient bit per clock, start/done handshake.
//   clk, rst            clock, asynchronous active-high reset
//   start               request, sampled only while idle
//   dividend, divisor   operands, captured when start is accepted
//   busy                high while running and in the done cycle
//   done                one-cycle pulse, results valid from this cycle
//   err                 divide-by-zero or quotient overflow, valid with done
//   quotient, remainder results, held until the next accepted start
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [W-1:0]   quotient,
    output logic [W-1:0]   remainder
);

    localparam int            CW        = $clog2(W) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

    logic [1:0]    state_r;
    // Partial remainder is always below the divisor between steps, so its
    // top (W+1-th) bit is identically zero and only W bits are kept; the
    // full W+1-bit value exists only as rem_shift_s / trial_s.
    logic [W-1:0]  rem_r;
    logic [W-1:0]  quo_r;
    logic [W-1:0]  dvs_r;
    logic [CW-1:0] count_r;
    logic          busy_r;
    logic          done_r;
    logic          err_r;
    logic [W-1:0]  quotient_r;
    logic [W-1:0]  remainder_r;

    logic [W:0]    rem_shift_s;
    logic [W:0]    trial_s;
    logic          borrow_s;
    logic          take_s;
    logic [W-1:0]  rem_next_s;
    logic [W-1:0]  quo_next_s;
    logic          bad_op_s;

    assign rem_shift_s = {rem_r, quo_r[W-1]};

    sub_cell #(.N(W + 1)) u_sub (
        .a      (rem_shift_s),
        .b      ({1'b0, dvs_r}),
        .diff   (trial_s),
        .borrow (borrow_s)
    );

    // One restoring step: keep the trial difference when it is non-negative.
    always_comb begin
        take_s     = 1'b0;
        rem_next_s = {W{1'b0}};
        quo_next_s = {W{1'b0}};
        // The shifted remainder is below 2*divisor, so a non-negative trial
        // has MSB 0 exactly when the subtractor reports no borrow.
        take_s     = ~trial_s[W] & ~borrow_s;
        quo_next_s = {quo_r[W-2:0], take_s};
        if (take_s) begin
            rem_next_s = trial_s[W-1:0];
        end else begin
            rem_next_s = rem_shift_s[W-1:0];
        end
    end

    // Quotient would not fit in W bits (or divisor is zero).
    always_comb begin
        bad_op_s = 1'b0;
        if (divisor == {W{1'b0}}) begin
            bad_op_s = 1'b1;
        end else begin
            bad_op_s = (dividend[2*W-1:W] >= divisor);
        end
    end

    // FSM, working registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= S_IDLE;
            rem_r       <= {W{1'b0}};
            quo_r       <= {W{1'b0}};
            dvs_r       <= {W{1'b0}};
            count_r     <= {CW{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            quotient_r  <= {W{1'b0}};
            remainder_r <= {W{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        busy_r <= 1'b1;
                        if (bad_op_s) begin
                            state_r     <= S_DONE;
                            done_r      <= 1'b1;
                            err_r       <= 1'b1;
                            quotient_r  <= {W{1'b1}};
                            remainder_r <= {W{1'b0}};
                        end else begin
                            state_r <= S_RUN;
                            rem_r   <= dividend[2*W-1:W];
                            quo_r   <= dividend[W-1:0];
                            dvs_r   <= divisor;
                            count_r <= {CW{1'b0}};
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                S_RUN: begin
                    rem_r   <= rem_next_s;
                    quo_r   <= quo_next_s;
                    count_r <= count_r + CW'(1);
                    if (count_r == LAST_STEP) begin
                        state_r     <= S_DONE;
                        done_r      <= 1'b1;
                        err_r       <= 1'b0;
                        quotient_r  <= quo_next_s;
                        remainder_r <= rem_next_s;
                    end else begin
                        state_r <= S_RUN;
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;
    assign quotient  = quotient_r;
    assign remainder = remainder_r;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard bench for seq_restoring_divider (W = 8).
module tb_seq_restoring_divider;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  quotient;
    logic [7:0]  remainder;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        int q;
        int r;
        int e;
        int acc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    seq_restoring_divider #(.W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .quotient  (quotient),
        .remainder (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer division with the W-bit overflow rule.
    function automatic exp_t model(input int dvd, input int dvs, input int acc);
        exp_t x;
        x.acc = acc;
        if (dvs == 0 || (dvd / dvs) > 255) begin
            x.q = 255;
            x.r = 0;
            x.e = 1;
        end else begin
            x.q = dvd / dvs;
            x.r = dvd % dvs;
            x.e = 0;
        end
        return x;
    endfunction

    // Monitor: every done pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1, expected no pulse (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("quotient", int'(quotient), mon_e.q);
                chk("remainder", int'(remainder), mon_e.r);
                chk("err", int'(err), mon_e.e);
                chk("latency", cyc - mon_e.acc, (mon_e.e != 0) ? 1 : 9);
                chk("busy_in_done", int'(busy), 1);
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        tests++;
        fails++;
        $display("FAIL idle_timeout: got busy=1, expected 0 within 200 cycles");
    endtask

    task automatic issue(input int dvd, input int dvs, input bit push);
        int acc;
        wait_idle();
        dividend = 16'(dvd);
        divisor  = 8'(dvs);
        start    = 1'b1;
        acc      = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (push) sb.push_back(model(dvd, dvs, acc));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_err"}, int'(err), 0);
        chk({tag, "_quotient"}, int'(quotient), 0);
        chk({tag, "_remainder"}, int'(remainder), 0);
    endtask

    initial begin
        int acc0;
        int acc1;
        int m;
        int q;
        int r;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = 16'd0;
        divisor  = 8'd0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        // Directed results and error responses.
        issue(30000, 150, 1'b1);
        issue(30001, 150, 1'b1);
        issue(65025, 255, 1'b1);
        issue(1234, 0, 1'b1);
        issue(16'h0100, 1, 1'b1);
        issue(255, 1, 1'b1);
        issue(65535, 255, 1'b1);

        // start during RUN with other operands must be ignored.
        issue(50000, 201, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        dividend = 16'd7;
        divisor  = 8'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;

        // start held high: back-to-back operations, one every 10 cycles.
        wait_idle();
        dividend = 16'd30000;
        divisor  = 8'd150;
        start    = 1'b1;
        acc0     = cyc;
        @(posedge clk);
        #1;
        sb.push_back(model(30000, 150, acc0));
        wait_idle();
        acc1 = cyc;
        @(posedge clk);
        #1;
        sb.push_back(model(30000, 150, acc1));
        chk("held_period", acc1 - acc0, 10);
        wait_idle();
        acc0 = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        sb.push_back(model(30000, 150, acc0));
        chk("held_period2", acc0 - acc1, 10);

        // Reset during RUN aborts with no done pulse.
        issue(40000, 199, 1'b0);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("midrun_reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        issue(12345, 67, 1'b1);

        // Random sweep with exact quotients and remainders.
        for (int k = 0; k < 40; k++) begin
            m = $urandom_range(255, 1);
            q = $urandom_range(255, 1);
            r = $urandom_range(q - 1, 0);
            issue(m * q + r, q, 1'b1);
        end

        // Fully random operands, including zero and overflow cases.
        for (int k = 0; k < 20; k++) begin
            issue($urandom_range(65535, 0), $urandom_range(255, 0), 1'b1);
        end

        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
